// File: rtl/enc_master_qp_rc.sv
// enc_master_qp_rc
// Encoder rate control. Produces the per-block masterQp from the bits
// spent by each coded block and from the rate buffer fullness.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   bits_per_component_coded    0:8 bpc, 1:10 bpc, 2:12 bpc, 3: same as 0
//   target_bits                 target bits per block (static within a slice)
//   buffer_fullness             rate buffer level, sampled at block acceptance
//   buffer_panic_thr            panic level for the rate buffer
//   slice_start                 one-cycle pulse, reloads the initial QP
//   block_bits / _valid / _ready  bits spent by the last block (valid/ready)
//   masterQp / _valid / _ready    resulting QP offered downstream (valid/ready)
module enc_master_qp_rc #(
  parameter int unsigned INIT_QP = 36,
  parameter int unsigned THR1    = 16,
  parameter int unsigned THR2    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  bits_per_component_coded,
  input  logic [11:0] target_bits,
  input  logic [15:0] buffer_fullness,
  input  logic [15:0] buffer_panic_thr,
  input  logic        slice_start,
  input  logic [11:0] block_bits,
  input  logic        block_bits_valid,
  output logic        block_bits_ready,
  output logic [6:0]  masterQp,
  output logic        masterQp_valid,
  input  logic        masterQp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int THR1_I = THR1;
  localparam int THR2_I = THR2;
  localparam logic signed [12:0] THR1_P = 13'(THR1_I);
  localparam logic signed [12:0] THR2_P = 13'(THR2_I);
  localparam logic signed [12:0] THR1_N = 13'(-THR1_I);
  localparam logic signed [12:0] THR2_N = 13'(-THR2_I);
  localparam logic signed [8:0]  INIT_QP_S = 9'(INIT_QP);
  localparam logic [6:0]         INIT_QP_R = 7'(INIT_QP);

  state_t             state_r;
  logic               started_r;
  logic [6:0]         qp_r;
  logic               valid_r;
  logic signed [12:0] diff_r;
  logic               panic_r;

  logic [6:0]         min_qp_s;
  logic signed [4:0]  delta_base_s;
  logic signed [4:0]  delta_s;
  logic signed [8:0]  new_qp_s;

  // Limit a signed QP candidate to [min_qp, 72].
  function automatic logic [6:0] clamp_qp(input logic signed [8:0] x,
                                          input logic [6:0] min_qp);
    logic [6:0] r;
    if (x < $signed({2'b00, min_qp})) begin
      r = min_qp;
    end else if (x > 9'sd72) begin
      r = 7'd72;
    end else begin
      r = x[6:0];
    end
    return r;
  endfunction

  // Lowest legal QP for the coded bit depth (code 3 behaves like 8 bpc).
  always_comb begin
    case (bits_per_component_coded)
      2'd1, 2'd2: min_qp_s = 7'd0;
      default:    min_qp_s = 7'd16;
    endcase
  end

  // QP step from the registered bit error; first matching band wins, panic adds 4.
  always_comb begin
    if (diff_r > THR2_P) begin
      delta_base_s = 5'sd3;
    end else if (diff_r > THR1_P) begin
      delta_base_s = 5'sd1;
    end else if (diff_r < THR2_N) begin
      delta_base_s = -5'sd3;
    end else if (diff_r < THR1_N) begin
      delta_base_s = -5'sd1;
    end else begin
      delta_base_s = 5'sd0;
    end
    if (panic_r) begin
      delta_s = delta_base_s + 5'sd4;
    end else begin
      delta_s = delta_base_s;
    end
    new_qp_s = $signed({2'b00, qp_r}) + $signed({{4{delta_s[4]}}, delta_s});
  end

  // Control FSM and QP register; slice_start overrides any state and drops an in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      started_r <= 1'b0;
      qp_r      <= INIT_QP_R;
      valid_r   <= 1'b0;
      diff_r    <= 13'sd0;
      panic_r   <= 1'b0;
    end else if (slice_start) begin
      started_r <= 1'b1;
      qp_r      <= clamp_qp(INIT_QP_S, min_qp_s);
      state_r   <= OUT;
      valid_r   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (block_bits_valid && block_bits_ready) begin
            diff_r  <= $signed({1'b0, block_bits} - {1'b0, target_bits});
            panic_r <= (buffer_fullness >= buffer_panic_thr);
            state_r <= CALC;
          end
        end
        CALC: begin
          qp_r    <= clamp_qp(new_qp_s, min_qp_s);
          state_r <= OUT;
          valid_r <= 1'b1;
        end
        OUT: begin
          if (masterQp_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign masterQp         = qp_r;
  assign masterQp_valid   = valid_r;
  assign block_bits_ready = (state_r == IDLE) && started_r;

endmodule

// File: tb/tb_enc_master_qp_rc.sv
module tb_enc_master_qp_rc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bits_per_component_coded;
  logic [11:0] target_bits;
  logic [15:0] buffer_fullness;
  logic [15:0] buffer_panic_thr;
  logic        slice_start;
  logic [11:0] block_bits;
  logic        block_bits_valid;
  logic        block_bits_ready;
  logic [6:0]  masterQp;
  logic        masterQp_valid;
  logic        masterQp_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: the QP the encoder should currently hold.
  int m_qp;
  int m_bpc;
  int m_tb;

  enc_master_qp_rc dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .bits_per_component_coded (bits_per_component_coded),
    .target_bits              (target_bits),
    .buffer_fullness          (buffer_fullness),
    .buffer_panic_thr         (buffer_panic_thr),
    .slice_start              (slice_start),
    .block_bits               (block_bits),
    .block_bits_valid         (block_bits_valid),
    .block_bits_ready         (block_bits_ready),
    .masterQp                 (masterQp),
    .masterQp_valid           (masterQp_valid),
    .masterQp_ready           (masterQp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_qp(input int bpc);
    return (bpc == 1 || bpc == 2) ? 0 : 16;
  endfunction

  function automatic int clampm(input int x, input int bpc);
    if (x < min_qp(bpc)) return min_qp(bpc);
    if (x > 72) return 72;
    return x;
  endfunction

  function automatic int next_qp(input int qp, input int bb, input int tb,
                                 input int full, input int thr, input int bpc);
    int d;
    int delta;
    d = bb - tb;
    if (d > 64)       delta = 3;
    else if (d > 16)  delta = 1;
    else if (d < -64) delta = -3;
    else if (d < -16) delta = -1;
    else              delta = 0;
    if (full >= thr) delta += 4;
    return clampm(qp + delta, bpc);
  endfunction

  // Caller is at a negedge with the DUT idle. Returns at a negedge with the DUT idle again.
  task automatic start_slice(input int bpc, input int tb);
    bits_per_component_coded = 2'(bpc);
    target_bits = 12'(tb);
    m_bpc = bpc;
    m_tb  = tb;
    slice_start = 1'b1;
    @(negedge clk);
    slice_start = 1'b0;
    m_qp = clampm(36, bpc);
    check("slice_valid", masterQp_valid, 1);
    check("slice_qp", masterQp, m_qp);
    check("slice_bready", block_bits_ready, 0);
    masterQp_ready = 1'b1;
    @(negedge clk);
    masterQp_ready = 1'b0;
    check("slice_idle_valid", masterQp_valid, 0);
    check("slice_idle_bready", block_bits_ready, 1);
  endtask

  task automatic do_block(input int bb, input int full, input int thr, input int hold);
    int waitc;
    block_bits = 12'(bb);
    buffer_fullness = 16'(full);
    buffer_panic_thr = 16'(thr);
    block_bits_valid = 1'b1;
    masterQp_ready = 1'b0;
    waitc = 0;
    while (!block_bits_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("hs_ready", block_bits_ready, 1);
    m_qp = next_qp(m_qp, bb, m_tb, full, thr, m_bpc);
    @(negedge clk);
    block_bits_valid = 1'b0;
    check("calc_valid", masterQp_valid, 0);
    check("calc_bready", block_bits_ready, 0);
    @(negedge clk);
    check("out_valid", masterQp_valid, 1);
    check("out_qp", masterQp, m_qp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", masterQp_valid, 1);
      check("hold_qp", masterQp, m_qp);
      check("hold_bready", block_bits_ready, 0);
    end
    masterQp_ready = 1'b1;
    @(negedge clk);
    masterQp_ready = 1'b0;
    check("ret_valid", masterQp_valid, 0);
    check("ret_bready", block_bits_ready, 1);
  endtask

  initial begin
    int bnd [9];
    rst_n = 1'b0;
    bits_per_component_coded = 2'd1;
    target_bits = 12'd200;
    buffer_fullness = 16'd0;
    buffer_panic_thr = 16'd1000;
    slice_start = 1'b0;
    block_bits = 12'd0;
    block_bits_valid = 1'b0;
    masterQp_ready = 1'b0;
    @(negedge clk);
    check("rst_qp", masterQp, 36);
    check("rst_valid", masterQp_valid, 0);
    check("rst_bready", block_bits_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Blocks offered before the first slice_start must not be accepted.
    block_bits_valid = 1'b1;
    block_bits = 12'd900;
    repeat (3) begin
      @(negedge clk);
      check("pre_bready", block_bits_ready, 0);
      check("pre_valid", masterQp_valid, 0);
    end
    block_bits_valid = 1'b0;

    // 10 bpc, diff +70 three times.
    start_slice(1, 200);
    repeat (3) do_block(270, 0, 1000, 0);
    check("seq_end_qp", masterQp, 45);

    // 8 bpc, diff -100 down to the floor, then -20.
    start_slice(0, 500);
    repeat (10) do_block(400, 0, 1000, 0);
    do_block(480, 0, 1000, 0);
    check("floor_qp", masterQp, 16);

    // Threshold boundaries at 12 bpc, including panic at equality.
    start_slice(2, 1000);
    bnd = '{16, 17, 64, 65, -16, -17, -64, -65, 0};
    for (int i = 0; i < 9; i++) do_block(1000 + bnd[i], 0, 1000, 0);
    do_block(1000, 777, 777, 0);
    do_block(1000, 776, 777, 0);

    // Ceiling: reach 70, panic pushes to 72, then a neutral block stays at 72.
    start_slice(1, 200);
    repeat (11) do_block(270, 0, 5000, 0);
    do_block(220, 0, 5000, 0);
    check("qp70", masterQp, 70);
    do_block(220, 5000, 5000, 5);
    check("ceil_qp", masterQp, 72);
    do_block(200, 0, 5000, 2);

    // slice_start in the CALC cycle drops the block.
    block_bits = 12'd0;
    block_bits_valid = 1'b1;
    @(negedge clk);
    block_bits_valid = 1'b0;
    slice_start = 1'b1;
    @(negedge clk);
    slice_start = 1'b0;
    check("calc_ss_valid", masterQp_valid, 1);
    check("calc_ss_qp", masterQp, 36);
    m_qp = 36;
    masterQp_ready = 1'b1;
    @(negedge clk);
    masterQp_ready = 1'b0;
    check("calc_ss_idle", block_bits_ready, 1);
    @(negedge clk);
    check("calc_ss_novalid", masterQp_valid, 0);

    // slice_start coincident with a block handshake.
    block_bits = 12'd4000;
    block_bits_valid = 1'b1;
    slice_start = 1'b1;
    @(negedge clk);
    block_bits_valid = 1'b0;
    slice_start = 1'b0;
    check("co_ss_valid", masterQp_valid, 1);
    check("co_ss_qp", masterQp, 36);
    masterQp_ready = 1'b1;
    @(negedge clk);
    masterQp_ready = 1'b0;
    check("co_ss_bready", block_bits_ready, 1);
    @(negedge clk);
    check("co_ss_novalid", masterQp_valid, 0);

    // Randomized blocks against the reference model.
    for (int n = 0; n < 80; n++) begin
      int bb;
      if ($urandom_range(0, 9) == 0)
        start_slice(int'($urandom_range(0, 3)), int'($urandom_range(100, 3900)));
      if ($urandom_range(0, 7) == 0) bb = int'($urandom_range(0, 4095));
      else bb = m_tb + int'($urandom_range(0, 200)) - 100;
      do_block(bb, int'($urandom_range(0, 1000)), int'($urandom_range(500, 1500)),
               int'($urandom_range(0, 3)));
    end

    // Reset while a QP is being offered.
    block_bits = 12'd3000;
    block_bits_valid = 1'b1;
    @(negedge clk);
    block_bits_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", masterQp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", masterQp_valid, 0);
    check("mid_rst_bready", block_bits_ready, 0);
    check("mid_rst_qp", masterQp, 36);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_bready", block_bits_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
